// File: rtl/popcount_pkg.sv
// Shared constants and helpers for the popcount frame arbiter.
// State encodings, popcount width and the saturating accumulator add.
package popcount_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    localparam int POPCNT_W = 4;

    function automatic int unsigned sat_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned max_val);
        int unsigned s;
        s = a + b;
        return (s > max_val) ? max_val : s;
    endfunction

endpackage

// File: rtl/popcount_byte.sv
// Combinational ones count of one byte.
// Result range is 0..8, so four bits are enough.
module popcount_byte
    import popcount_pkg::*;
(
    input  logic [7:0]          data,
    output logic [POPCNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + POPCNT_W'(data[i]);
        end
    end

endmodule

// File: rtl/popcount_frame_arbiter.sv
// Round-robin frame arbiter in front of one shared byte popcount unit.
// Grants one requester per frame, accumulates a saturating ones count, then returns it.
module popcount_frame_arbiter
    import popcount_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int ACC_W = 8,
    parameter int IDW   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_count,
    output logic [IDW-1:0]    res_id,
    output logic              res_overflow
);

    localparam int unsigned ACC_MAX = (32'd1 << ACC_W) - 32'd1;

    logic [1:0]          state;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      grant_id;
    logic [ACC_W-1:0]    acc;
    logic                ovf;

    logic                pick_found;
    logic [IDW-1:0]      pick_id;
    logic [IDW-1:0]      idx;
    logic [7:0]          grant_byte;
    logic [POPCNT_W-1:0] byte_cnt;
    logic                beat;
    logic                ovf_now;
    logic [ACC_W-1:0]    acc_next;

    // Search starts at the pointer so the last-served requester ends up last in line.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (!pick_found && req_valid[idx]) begin
                pick_found = 1'b1;
                pick_id    = idx;
            end
        end
    end

    assign grant_byte = req_data[{grant_id, 3'b000} +: 8];

    popcount_byte u_popcount_byte (
        .data  (grant_byte),
        .count (byte_cnt)
    );

    assign beat     = (state == BUSY) && req_valid[grant_id];
    assign ovf_now  = (32'(acc) + 32'(byte_cnt)) > ACC_MAX;
    assign acc_next = ACC_W'(sat_add(32'(acc), 32'(byte_cnt), ACC_MAX));

    always_comb begin
        req_ready = '0;
        if (state == BUSY) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign res_valid = (state == RESULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ptr          <= '0;
            grant_id     <= '0;
            acc          <= '0;
            ovf          <= 1'b0;
            res_count    <= '0;
            res_id       <= '0;
            res_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_id;
                        acc      <= '0;
                        ovf      <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (beat) begin
                        acc <= acc_next;
                        ovf <= ovf | ovf_now;
                        // The result includes the last byte itself.
                        if (req_last[grant_id]) begin
                            res_count    <= acc_next;
                            res_id       <= grant_id;
                            res_overflow <= ovf | ovf_now;
                            state        <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        ptr   <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/popcount_frame_arbiter.md
Name: popcount_frame_arbiter

Overview:
- Shares one 8-bit ones-count datapath among NREQ requesters.
- Each requester submits a frame: a sequence of bytes on a valid/ready handshake, with the final byte flagged by last.
- The arbiter grants one requester per frame in round-robin order, accumulates the ones count of every byte in the frame, and presents the frame total plus the requester ID on an output valid/ready handshake.
- It sits between the byte producers and the single shared popcount unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ACC_W, 8, width of the frame accumulator and of res_count.
- IDW, 2, width of res_id; must equal clog2(NREQ).

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, synchronous active-high reset.
- req_valid, input, NREQ, per-requester byte valid.
- req_data, input, 8*NREQ, byte of requester k at bits [8k+7:8k].
- req_last, input, NREQ, marks the final byte of the frame; qualified by valid.
- req_ready, output, NREQ, per-requester accept; at most one bit set.
- res_valid, output, 1, frame result available.
- res_ready, input, 1, consumer accepts the result.
- res_count, output, ACC_W, total ones in the frame.
- res_id, output, IDW, requester that owned the frame.
- res_overflow, output, 1, accumulator saturated during the frame.

Behaviour:
- Reset (synchronous, active-high) values:
  - req_ready=0, res_valid=0, res_count=0, res_id=0, res_overflow=0.
  - Round-robin pointer = 0; state = IDLE.
  - Reset mid-frame or mid-result discards all work. No partial result is ever emitted.
- States: IDLE, BUSY, RESULT.
- IDLE:
  - req_ready = 0.
  - If any req_valid is set, select the first set bit at or after the pointer, wrapping modulo NREQ.
  - Register it as grant_id, clear acc and ovf, go to BUSY. No byte is consumed in this cycle.
- BUSY:
  - req_ready[grant_id] = 1; all other bits are 0.
  - A beat is accepted on req_valid[grant_id] & req_ready[grant_id].
  - Accepted beat: acc <= sat(acc + popcount(byte)).
  - sat() clamps to 2^ACC_W-1 and sets ovf sticky. popcount range is 0..8 and is zero-extended.
  - Accepted beat with last: load res_count with the final sum (including this byte), res_id = grant_id, res_overflow = ovf, go to RESULT.
  - The grant holds while the owner deasserts valid mid-frame; the arbiter waits indefinitely. Other requesters are ignored.
- RESULT:
  - res_valid = 1 and req_ready = 0.
  - res_count, res_id and res_overflow stay stable until res_ready is seen.
  - On res_valid & res_ready: pointer <= (grant_id+1) mod NREQ, go to IDLE.
  - res_ready held high has no early effect; the result is consumed only in RESULT.
- Latency:
  - First req_valid in IDLE at cycle t gives req_ready at t+1.
  - A last byte accepted at cycle u gives res_valid at u+1.
  - Minimum frame-to-frame gap is 2 cycles (RESULT, then IDLE).
- Single-byte frame (last on the first beat) is legal.
- Fairness: after serving k, requester k has the lowest priority for the next grant. No requester waits more than NREQ-1 frames.
- Simultaneous events:
  - A new req_valid arriving in RESULT is held off until IDLE.
  - req_valid from a non-granted requester never changes acc.

Decomposition:
- Package popcount_pkg holds:
  - the state encoding constants IDLE/BUSY/RESULT;
  - the POPCNT_W=4 constant;
  - a function for the saturating add.
- One sub-module, popcount_byte: combinational 8-bit ones count to 4 bits. It is instantiated once, fed by a mux of req_data indexed by grant_id.
- The arbiter FSM and accumulator live in the top module.

Test Plan:
- Single requester 0, frame 8'b10100111, 8'b11111111, 8'b00000000 (last) -> res_count=13, res_id=0, res_overflow=0, res_valid one cycle after the last beat.
- Requesters 1 and 3 valid together after reset (pointer 0):
  - requester 1 is served first; its frame 8'b01101100 (last) -> res_count=4, res_id=1.
  - requester 3 is served next; its frame 8'b11010001 (last) -> res_count=4, res_id=3.
- All four requesters continuously valid with one-byte frames of 8'b11100000 -> res_id sequence 0,1,2,3,0; every res_count=3.
- Overflow: requester 2 sends 32 bytes of 8'hFF then 8'h01 (last) -> res_count=255, res_overflow=1.
- Backpressure and stall cases:
  - Hold res_ready=0 for 5 cycles -> res_valid stays 1, outputs stable, all req_ready=0.
  - Owner drops valid for 3 cycles mid-frame -> acc unchanged; the final total is correct.
- Reset asserted in BUSY after 2 bytes -> next cycle all outputs 0. A new frame 8'b10000111 (last) from requester 2 -> res_count=4, with no residue from the aborted frame.
